mem_wb_skid: RTL and testbench

Parametrised MEM/WB pipeline boundary with a valid/ready handshake and a 2-entry skid buffer. It carries N_WR general-register write channels plus one HI/LO write channel from the memory stage to write-back. It supports back-pressure from write-back, a synchronous flush, and full one-per-cycle throughput. The `in_ready` output is driven from a flop only, so there is no combinational path from `out_ready` to `in_ready`.

---
 rtl/mem_wb_skid.sv | 110 +++++++++++
 tb/tb_mem_wb_skid.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_skid.sv
// MEM/WB pipeline boundary with a valid/ready handshake and a 2-entry skid buffer.
// Carries N_WR register write channels plus one HI/LO channel. in_ready comes straight
// from the skid-valid flop, so out_ready never reaches in_ready combinationally.
module mem_wb_skid #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned N_WR   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_WR-1:0]          in_reg,
    input  logic [N_WR*ADDR_W-1:0]   in_waddr,
    input  logic [N_WR*DATA_W-1:0]   in_wdata,
    input  logic                     in_whilo,
    input  logic [DATA_W-1:0]        in_hi,
    input  logic [DATA_W-1:0]        in_lo,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_WR-1:0]          out_reg,
    output logic [N_WR*ADDR_W-1:0]   out_waddr,
    output logic [N_WR*DATA_W-1:0]   out_wdata,
    output logic                     out_whilo,
    output logic [DATA_W-1:0]        out_hi,
    output logic [DATA_W-1:0]        out_lo,
    output logic [1:0]               occupancy
);

    // Packed payload layout: {reg, waddr, wdata, whilo, hi, lo}
    localparam int unsigned PW = N_WR + N_WR * ADDR_W + N_WR * DATA_W + 1 + 2 * DATA_W;

    logic          main_valid_q, main_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic [PW-1:0] main_q, main_d;
    logic [PW-1:0] skid_q, skid_d;
    logic [PW-1:0] in_pl;
    logic          accept;
    logic          consume;

    logic [N_WR-1:0]        m_reg;
    logic [N_WR*ADDR_W-1:0] m_waddr;
    logic [N_WR*DATA_W-1:0] m_wdata;
    logic                   m_whilo;
    logic [DATA_W-1:0]      m_hi;
    logic [DATA_W-1:0]      m_lo;

    assign in_pl   = {in_reg, in_waddr, in_wdata, in_whilo, in_hi, in_lo};
    assign in_ready = ~skid_valid_q;
    assign accept  = in_valid & in_ready;
    assign consume = main_valid_q & out_ready;

    // Next-state: flush wins; a full buffer only drains; skid is never bypassed.
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (consume) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (main_valid_q) begin
            if (accept && consume) begin
                main_d = in_pl;
            end else if (accept) begin
                skid_d       = in_pl;
                skid_valid_d = 1'b1;
            end else if (consume) begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            main_d       = in_pl;
            main_valid_d = 1'b1;
        end
    end

    // State registers; reset clears valids and every payload bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    assign {m_reg, m_waddr, m_wdata, m_whilo, m_hi, m_lo} = main_q;

    // Write enables are gated so write-back can never act on a stale entry.
    assign out_valid = main_valid_q;
    assign out_reg   = m_reg & {N_WR{main_valid_q}};
    assign out_whilo = m_whilo & main_valid_q;
    assign out_waddr = m_waddr;
    assign out_wdata = m_wdata;
    assign out_hi    = m_hi;
    assign out_lo    = m_lo;
    assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_mem_wb_skid.sv
// Self-checking bench for mem_wb_skid (N_WR=2): directed vector table, hand-written
// corner sequences, and a randomised run against a queue model.
module tb_mem_wb_skid;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_reg;
    logic [9:0]  in_waddr;
    logic [63:0] in_wdata;
    logic        in_whilo;
    logic [31:0] in_hi;
    logic [31:0] in_lo;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_reg;
    logic [9:0]  out_waddr;
    logic [63:0] out_wdata;
    logic        out_whilo;
    logic [31:0] out_hi;
    logic [31:0] out_lo;
    logic [1:0]  occupancy;

    int total = 0;
    int bad   = 0;

    mem_wb_skid #(
        .DATA_W(32),
        .ADDR_W(5),
        .N_WR  (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_reg   (in_reg),
        .in_waddr (in_waddr),
        .in_wdata (in_wdata),
        .in_whilo (in_whilo),
        .in_hi    (in_hi),
        .in_lo    (in_lo),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_reg  (out_reg),
        .out_waddr(out_waddr),
        .out_wdata(out_wdata),
        .out_whilo(out_whilo),
        .out_hi   (out_hi),
        .out_lo   (out_lo),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        f;
        logic        v;
        logic        r;
        logic [1:0]  rg;
        logic        wh;
        logic [31:0] w;
        logic        e_valid;
        logic        e_ready;
        logic [1:0]  e_occ;
        logic [31:0] e_w;
        logic [1:0]  e_reg;
        logic        e_whilo;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: act=%0h req=%0h", name, act, exp);
        end
    endtask

    // Every other payload field is derived from the channel-0 data word.
    task automatic drive(input logic f, input logic v, input logic r, input logic [1:0] rg,
                         input logic wh, input logic [31:0] w);
        flush     = f;
        in_valid  = v;
        out_ready = r;
        in_reg    = rg;
        in_whilo  = wh;
        in_waddr  = {w[4:0] + 5'd1, w[4:0]};
        in_wdata  = {~w, w};
        in_hi     = w ^ 32'hFFFF0000;
        in_lo     = w + 32'd1;
    endtask

    task automatic check_entry(input string name, input logic [31:0] w);
        logic [4:0] a;
        a = w[4:0];
        check({name, ".wdata"}, out_wdata, {~w, w});
        check({name, ".waddr"}, {54'd0, out_waddr}, {54'd0, a + 5'd1, a});
        check({name, ".hi"}, {32'd0, out_hi}, {32'd0, w ^ 32'hFFFF0000});
        check({name, ".lo"}, {32'd0, out_lo}, {32'd0, w + 32'd1});
    endtask

    vec_t vecs[16];
    logic [31:0] q[$];

    initial begin
        // f v r rg wh w           | valid ready occ e_w reg whilo
        vecs[0]  = '{0, 1, 0, 2'b11, 0, 32'hAAAA, 1, 1, 1, 32'hAAAA, 2'b11, 0};
        vecs[1]  = '{0, 1, 0, 2'b01, 0, 32'hBBBB, 1, 0, 2, 32'hAAAA, 2'b11, 0};
        vecs[2]  = '{0, 1, 0, 2'b10, 1, 32'hCCCC, 1, 0, 2, 32'hAAAA, 2'b11, 0};
        vecs[3]  = '{0, 1, 1, 2'b10, 1, 32'hCCCC, 1, 1, 1, 32'hBBBB, 2'b01, 0};
        vecs[4]  = '{0, 1, 0, 2'b10, 1, 32'hCCCC, 1, 0, 2, 32'hBBBB, 2'b01, 0};
        vecs[5]  = '{0, 0, 1, 2'b00, 0, 32'h0,    1, 1, 1, 32'hCCCC, 2'b10, 1};
        vecs[6]  = '{0, 0, 1, 2'b00, 0, 32'h0,    0, 1, 0, 32'h0,    2'b00, 0};
        vecs[7]  = '{0, 1, 1, 2'b11, 1, 32'hD0,   1, 1, 1, 32'hD0,   2'b11, 1};
        vecs[8]  = '{0, 1, 1, 2'b01, 0, 32'hE0,   1, 1, 1, 32'hE0,   2'b01, 0};
        vecs[9]  = '{0, 1, 0, 2'b00, 1, 32'hF0,   1, 0, 2, 32'hE0,   2'b01, 0};
        vecs[10] = '{1, 1, 1, 2'b11, 1, 32'h99,   0, 1, 0, 32'h0,    2'b00, 0};
        vecs[11] = '{1, 1, 0, 2'b11, 1, 32'h60,   0, 1, 0, 32'h0,    2'b00, 0};
        vecs[12] = '{0, 0, 1, 2'b00, 0, 32'h0,    0, 1, 0, 32'h0,    2'b00, 0};
        vecs[13] = '{0, 1, 0, 2'b11, 1, 32'h77,   1, 1, 1, 32'h77,   2'b11, 1};
        vecs[14] = '{1, 1, 1, 2'b11, 1, 32'h88,   0, 1, 0, 32'h0,    2'b00, 0};
        vecs[15] = '{0, 0, 0, 2'b00, 0, 32'h0,    0, 1, 0, 32'h0,    2'b00, 0};

        // Reset state
        rst = 1'b0;
        drive(0, 0, 0, 2'b00, 0, 32'h0);
        #2;
        check("rst.valid", {63'd0, out_valid}, 64'd0);
        check("rst.ready", {63'd0, in_ready}, 64'd1);
        check("rst.occ", {62'd0, occupancy}, 64'd0);
        check("rst.reg", {62'd0, out_reg}, 64'd0);
        check("rst.wdata", out_wdata, 64'd0);
        check("rst.waddr", {54'd0, out_waddr}, 64'd0);
        check("rst.hilo", {out_hi, out_lo}, 64'd0);
        #10 rst = 1'b1;

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].f, vecs[i].v, vecs[i].r, vecs[i].rg, vecs[i].wh, vecs[i].w);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.valid", i), {63'd0, out_valid}, {63'd0, vecs[i].e_valid});
            check($sformatf("vec%0d.ready", i), {63'd0, in_ready}, {63'd0, vecs[i].e_ready});
            check($sformatf("vec%0d.occ", i), {62'd0, occupancy}, {62'd0, vecs[i].e_occ});
            check($sformatf("vec%0d.reg", i), {62'd0, out_reg}, {62'd0, vecs[i].e_reg});
            check($sformatf("vec%0d.whilo", i), {63'd0, out_whilo}, {63'd0, vecs[i].e_whilo});
            if (vecs[i].e_valid) check_entry($sformatf("vec%0d", i), vecs[i].e_w);
        end

        // HI/LO channel, then gating of the stale whilo bit
        drive(0, 1, 1, 2'b01, 1, 32'h1234);
        in_hi = 32'hDEADBEEF;
        in_lo = 32'h12345678;
        @(posedge clk);
        #1;
        check("hilo.hi", {32'd0, out_hi}, {32'd0, 32'hDEADBEEF});
        check("hilo.lo", {32'd0, out_lo}, {32'd0, 32'h12345678});
        check("hilo.whilo", {63'd0, out_whilo}, 64'd1);
        drive(0, 0, 1, 2'b00, 0, 32'h0);
        @(posedge clk);
        #1;
        check("hilo.gate_valid", {63'd0, out_valid}, 64'd0);
        check("hilo.gate_whilo", {63'd0, out_whilo}, 64'd0);
        check("hilo.gate_reg", {62'd0, out_reg}, 64'd0);

        // Asynchronous reset while FULL, taken between edges
        drive(0, 1, 0, 2'b11, 1, 32'h31);
        @(posedge clk);
        #1;
        drive(0, 1, 0, 2'b11, 1, 32'h32);
        @(posedge clk);
        #1;
        check("ar.full", {62'd0, occupancy}, 64'd2);
        drive(0, 0, 0, 2'b00, 0, 32'h0);
        #2 rst = 1'b0;
        #1;
        check("ar.valid", {63'd0, out_valid}, 64'd0);
        check("ar.ready", {63'd0, in_ready}, 64'd1);
        check("ar.occ", {62'd0, occupancy}, 64'd0);
        check("ar.wdata", out_wdata, 64'd0);
        check("ar.hilo", {out_hi, out_lo}, 64'd0);
        check("ar.whilo", {63'd0, out_whilo}, 64'd0);
        #2 rst = 1'b1;
        drive(0, 1, 0, 2'b01, 0, 32'h55);
        @(posedge clk);
        #1;
        check("ar.first_valid", {63'd0, out_valid}, 64'd1);
        check("ar.first_wdata", {32'd0, out_wdata[31:0]}, 64'h55);
        check("ar.first_occ", {62'd0, occupancy}, 64'd1);
        drive(0, 0, 1, 2'b00, 0, 32'h0);
        @(posedge clk);
        #1;

        // Streaming: 8 back-to-back entries with out_ready held high
        for (int i = 1; i <= 8; i++) begin
            drive(0, 1, 1, 2'b11, 0, 32'h100 + i);
            @(posedge clk);
            #1;
            check($sformatf("str%0d.valid", i), {63'd0, out_valid}, 64'd1);
            check($sformatf("str%0d.ready", i), {63'd0, in_ready}, 64'd1);
            check_entry($sformatf("str%0d", i), 32'h100 + i);
        end
        drive(0, 0, 1, 2'b00, 0, 32'h0);
        @(posedge clk);
        #1;
        check("str.end_valid", {63'd0, out_valid}, 64'd0);

        // Randomised traffic against a queue model
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            logic f, v, r;
            logic [31:0] w;
            int sz;
            f = ($urandom_range(0, 31) == 0);
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            w = $urandom;
            drive(f, v, r, 2'(w[1:0]), w[2], w);
            #1;
            sz = q.size();
            check("rnd.valid", {63'd0, out_valid}, {63'd0, sz != 0});
            check("rnd.ready", {63'd0, in_ready}, {63'd0, sz < 2});
            check("rnd.occ", {62'd0, occupancy}, 64'(sz));
            if (sz != 0) begin
                check("rnd.wdata", {32'd0, out_wdata[31:0]}, {32'd0, q[0]});
                check("rnd.lo", {32'd0, out_lo}, {32'd0, q[0] + 32'd1});
            end
            if (f) begin
                q.delete();
            end else begin
                if (sz != 0 && r) void'(q.pop_front());
                if (v && sz < 2) q.push_back(w);
            end
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
